register_file_32: RTL and testbench



---
 rtl/register_file_32_pkg.sv | 21 ++
 rtl/register_file_32.sv | 74 +++++++
 tb/tb_register_file_32.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/register_file_32_pkg.sv
// register_file_32_pkg
//   Shared constants for the mips32 register file and the blocks that
//   decode register indices (decoder, tests).
//   - REG_ADDR_WIDTH / WORD_WIDTH : default geometry of the register file
//   - REG_ZERO                    : index of the hardwired $zero register
//   - REG_AT, REG_V0, REG_SP, REG_RA : named MIPS register indices
package register_file_32_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int WORD_WIDTH     = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_V0   = 2;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_32.sv
// register_file_32
//   32 x 32-bit MIPS general-purpose register file. Two combinational read
//   ports (rs/rt) and one synchronous write port. Register 0 is hardwired
//   to zero. There is no write-to-read bypass: a read of the register being
//   written shows the old value until the clock edge.
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous active-high clear of every register
//   read_reg_1   : rs index          -> read_data_1 (comparator input a)
//   read_reg_2   : rt index          -> read_data_2 (comparator input b)
//   write_reg    : write-back destination index
//   write_data   : write-back value
//   reg_write    : write enable
module register_file_32
  import register_file_32_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  // Must equal 2**ADDR_WIDTH so every index decodes to a real register.
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

  // One flop bank per register with its own decoded enable. Register 0 is
  // kept as a constant-zero bank so the array is fully defined; the read
  // muxes still override index 0 so $zero never depends on stored state.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == REG_ZERO) begin : g_zero
        always_ff @(posedge clk) begin
          regs_reg[gi] <= '0;
        end
      end else begin : g_gpr
        logic wr_en;
        assign wr_en = reg_write && (write_reg == ADDR_WIDTH'(gi));

        // Reset has priority: a write coincident with reset is dropped.
        always_ff @(posedge clk) begin
          if (reset) begin
            regs_reg[gi] <= '0;
          end else if (wr_en) begin
            regs_reg[gi] <= write_data;
          end
        end
      end
    end
  endgenerate

  // Read straight from the register state with no forwarding of
  // write_data; a bypass here would close a combinational loop through
  // the ALU in the single-cycle datapath.
  always_comb begin
    read_data_1 = regs_reg[read_reg_1];
    read_data_2 = regs_reg[read_reg_2];
    if (read_reg_1 == ZERO_IDX) read_data_1 = '0;
    if (read_reg_2 == ZERO_IDX) read_data_2 = '0;
  end

endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32
//   Self-checking bench for register_file_32: directed cases for reset,
//   $zero, dual-port reads, no-bypass, reset priority and write enable,
//   followed by randomized traffic checked against an array model.
module tb_register_file_32;
  import register_file_32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  always #5 clk = ~clk;

  register_file_32 dut (
    .clk         (clk),
    .reset       (reset),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .reg_write   (reg_write),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  // Reference: plain array of register contents; index 0 is never written.
  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply one rising edge and update the model from the inputs presented.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (reg_write && write_reg != 5'(REG_ZERO)) begin
      model[write_reg] = write_data;
    end
    #1;
  endtask

  task automatic set_read(input logic [4:0] a, input logic [4:0] b);
    read_reg_1 = a;
    read_reg_2 = b;
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_p1"}, read_data_1, model[read_reg_1]);
    check({tag, "_p2"}, read_data_2, model[read_reg_2]);
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = r;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg_1 = '0; read_reg_2 = '0;
    #2;

    // Reset clears everything
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 5'(31 - i));
      check($sformatf("reset_r%0d_p1", i), read_data_1, 32'h0);
      check($sformatf("reset_r%0d_p2", i), read_data_2, 32'h0);
    end

    // 1. reset clears a written register
    do_write(5'd5, 32'hDEADBEEF);
    set_read(5'd5, 5'd5);
    check("r5_written", read_data_1, 32'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_read(5'd5, 5'd0);
    check("reset_clear_r5", read_data_1, 32'h0);

    // 2. writes to $zero discarded
    do_write(5'(REG_ZERO), 32'hFFFFFFFF);
    set_read(5'd0, 5'd0);
    check("zero_p1", read_data_1, 32'h0);
    check("zero_p2", read_data_2, 32'h0);

    // 3. both ports, same register on both ports
    do_write(5'd8, 32'h00000001);
    do_write(5'd9, 32'hFFFFFFFF);
    set_read(5'd8, 5'd9);
    check("r8_p1", read_data_1, 32'h00000001);
    check("r9_p2", read_data_2, 32'hFFFFFFFF);
    set_read(5'd9, 5'd9);
    check("r9r9_p1", read_data_1, 32'hFFFFFFFF);
    check("r9r9_p2", read_data_2, 32'hFFFFFFFF);
    check("r9r9_equal", {31'h0, read_data_1 == read_data_2}, 32'h1);

    // 4. no bypass: old value before the edge, new after
    do_write(5'd10, 32'h00040000);
    set_read(5'd10, 5'd10);
    reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h00410000;
    #1;
    check("nobypass_pre_p1", read_data_1, 32'h00040000);
    check("nobypass_pre_p2", read_data_2, 32'h00040000);
    tick();
    reg_write = 1'b0;
    check("nobypass_post_p1", read_data_1, 32'h00410000);
    check("nobypass_post_p2", read_data_2, 32'h00410000);

    // 5. reset beats a simultaneous write
    do_write(5'(REG_RA), 32'h11111111);
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'(REG_RA); write_data = 32'h80451C00;
    tick();
    reset = 1'b0; reg_write = 1'b0;
    set_read(5'(REG_RA), 5'(REG_SP));
    check("reset_prio_ra", read_data_1, 32'h0);

    // 6. write enable low keeps state
    do_write(5'(REG_RA), 32'h80451C00);
    reg_write = 1'b0; write_reg = 5'(REG_RA); write_data = 32'h12345678;
    tick();
    set_read(5'(REG_RA), 5'(REG_RA));
    check("we_low_ra", read_data_1, 32'h80451C00);

    // Back-to-back writes to one register: last wins
    do_write(5'(REG_V0), 32'hA5A5A5A5);
    do_write(5'(REG_V0), 32'h5A5A5A5A);
    set_read(5'(REG_V0), 5'(REG_AT));
    check("b2b_v0", read_data_1, 32'h5A5A5A5A);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      reg_write  = 1'($urandom_range(0, 1));
      write_reg  = 5'($urandom);
      write_data = $urandom;
      read_reg_1 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
      read_reg_2 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
      #1;
      check_reads("rnd_pre");
      tick();
      check_reads("rnd_post");
    end
    reset = 1'b0; reg_write = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
